// File: rtl/ifid_pipe_reg.sv
// ---------------------------------------------------------------------------
// ifid_pipe_reg
//
// IF/ID pipeline register for the modified MIPS core. It captures the fetched
// instruction word and PC+4 on each rising clock edge and presents the
// instruction already split into every field view used by the decode stage
// (R, I, J, FR and FI formats). All views are driven at the same time. No
// opcode decoding is done here.
//
// Control priority on each rising edge: flush > stall (en=0) > load (en=1).
// A flush inserts a bubble: the instruction becomes NOP (all zeros), PC+4
// becomes 0 and valid becomes 0.
//
// Optional feature (macro IFID_DECODE_FLAGS_EN):
//   When the macro is defined, three more outputs appear: is_r, is_j and
//   is_fp. They are coarse format flags taken from the opcode and are forced
//   to 0 while the stage holds a bubble. When the macro is undefined, these
//   ports do not exist.
//
// Ports:
//   clk     in   1   pipeline clock, rising-edge active
//   rst_n   in   1   asynchronous active-low reset
//   pcp4    in  32   PC+4 from IF
//   ins     in  32   fetched instruction from IF
//   en      in   1   load enable; 0 holds contents (stall)
//   flush   in   1   synchronous bubble insert; wins over en
//   pcp4o   out 32   registered PC+4
//   op      out  6   instr[31:26]
//   rs_fmt  out  5   instr[25:21]  rs / fmt
//   rt_ft   out  5   instr[20:16]  rt / ft
//   rd_fs   out  5   instr[15:11]  rd / fs
//   sh_fd   out  5   instr[10:6]   shamt / fd
//   fun     out  6   instr[5:0]
//   im      out 16   instr[15:0]
//   im_se   out 32   im sign-extended
//   ad      out 26   instr[25:0] jump target (no PC bits added)
//   valid   out  1   1 = real instruction, 0 = bubble
//   is_r    out  1   (IFID_DECODE_FLAGS_EN only) op == SPECIAL
//   is_j    out  1   (IFID_DECODE_FLAGS_EN only) op == J or JAL
//   is_fp   out  1   (IFID_DECODE_FLAGS_EN only) op == COP1
// ---------------------------------------------------------------------------
module ifid_pipe_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] pcp4,
    input  logic [DATA_W-1:0] ins,
    input  logic              en,
    input  logic              flush,
    output logic [DATA_W-1:0] pcp4o,
    output logic [5:0]        op,
    output logic [4:0]        rs_fmt,
    output logic [4:0]        rt_ft,
    output logic [4:0]        rd_fs,
    output logic [4:0]        sh_fd,
    output logic [5:0]        fun,
    output logic [15:0]       im,
    output logic [31:0]       im_se,
    output logic [25:0]       ad,
`ifdef IFID_DECODE_FLAGS_EN
    output logic              is_r,
    output logic              is_j,
    output logic              is_fp,
`endif
    output logic              valid
);

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_COP1    = 6'b010001;

    logic [DATA_W-1:0] ir_q;
    logic [DATA_W-1:0] pr_q;
    logic              v_q;

    // NOTE: the state registers use non-blocking assignments, so every
    // register samples the values from before the edge, whatever the order
    // of the statements.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q <= '0;
            pr_q <= '0;
            v_q  <= 1'b0;
        end else if (flush) begin
            ir_q <= '0;
            pr_q <= '0;
            v_q  <= 1'b0;
        end else if (en) begin
            ir_q <= ins;
            pr_q <= pcp4;
            v_q  <= 1'b1;
        end
    end

    // The field views are plain slices of IR. Every format is presented at
    // the same time, and decode picks the view it needs.
    assign pcp4o  = pr_q;
    assign op     = ir_q[31:26];
    assign rs_fmt = ir_q[25:21];
    assign rt_ft  = ir_q[20:16];
    assign rd_fs  = ir_q[15:11];
    assign sh_fd  = ir_q[10:6];
    assign fun    = ir_q[5:0];
    assign im     = ir_q[15:0];
    assign im_se  = {{16{ir_q[15]}}, ir_q[15:0]};
    assign ad     = ir_q[25:0];
    assign valid  = v_q;

`ifdef IFID_DECODE_FLAGS_EN
    // A bubble already holds IR=0, and that decodes as SPECIAL. The valid
    // gate keeps is_r low for bubbles.
    assign is_r  = v_q && (ir_q[31:26] == OP_SPECIAL);
    assign is_j  = v_q && ((ir_q[31:26] == OP_J) || (ir_q[31:26] == OP_JAL));
    assign is_fp = v_q && (ir_q[31:26] == OP_COP1);
`endif

endmodule

// File: tb/tb_ifid_pipe_reg.sv
// ---------------------------------------------------------------------------
// tb_ifid_pipe_reg
//
// Directed testbench for ifid_pipe_reg. Every expected value is worked out
// by hand from the instruction encodings. Inputs are driven and outputs are
// sampled 1 ns after the rising edge. The flag outputs are checked when
// IFID_DECODE_FLAGS_EN is defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ifid_pipe_reg;

    logic        clk;
    logic        rst_n;
    logic [31:0] pcp4;
    logic [31:0] ins;
    logic        en;
    logic        flush;
    logic [31:0] pcp4o;
    logic [5:0]  op;
    logic [4:0]  rs_fmt;
    logic [4:0]  rt_ft;
    logic [4:0]  rd_fs;
    logic [4:0]  sh_fd;
    logic [5:0]  fun;
    logic [15:0] im;
    logic [31:0] im_se;
    logic [25:0] ad;
    logic        valid;
`ifdef IFID_DECODE_FLAGS_EN
    logic        is_r;
    logic        is_j;
    logic        is_fp;
`endif

    int n_checks = 0;
    int n_errors = 0;

    ifid_pipe_reg #(.DATA_W(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .pcp4   (pcp4),
        .ins    (ins),
        .en     (en),
        .flush  (flush),
        .pcp4o  (pcp4o),
        .op     (op),
        .rs_fmt (rs_fmt),
        .rt_ft  (rt_ft),
        .rd_fs  (rd_fs),
        .sh_fd  (sh_fd),
        .fun    (fun),
        .im     (im),
        .im_se  (im_se),
        .ad     (ad),
`ifdef IFID_DECODE_FLAGS_EN
        .is_r   (is_r),
        .is_j   (is_j),
        .is_fp  (is_fp),
`endif
        .valid  (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Wait for one rising edge, then settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".pcp4o"}, pcp4o, 32'h0);
        check({tag, ".op"},    {26'h0, op}, 32'h0);
        check({tag, ".im_se"}, im_se, 32'h0);
        check({tag, ".ad"},    {6'h0, ad}, 32'h0);
        check({tag, ".valid"}, {31'h0, valid}, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        flush = 1'b0;
        ins   = 32'h0;
        pcp4  = 32'h0;

        // Reset is active before any clock edge.
        #3;
        check_all_zero("rst0");
        rst_n = 1'b1;

        // Load A8221FF8, PC+4 = 4.
        ins  = 32'hA8221FF8;
        pcp4 = 32'd4;
        en   = 1'b1;
        #1;
        check("pre_edge.valid", {31'h0, valid}, 32'h0);
        tick();
        check("ld1.op",     {26'h0, op},     32'h2A);   // 101010
        check("ld1.rs_fmt", {27'h0, rs_fmt}, 32'h01);
        check("ld1.rt_ft",  {27'h0, rt_ft},  32'h02);
        check("ld1.rd_fs",  {27'h0, rd_fs},  32'h03);
        check("ld1.sh_fd",  {27'h0, sh_fd},  32'h1F);
        check("ld1.fun",    {26'h0, fun},    32'h38);   // 111000
        check("ld1.pcp4o",  pcp4o,           32'd4);
        check("ld1.valid",  {31'h0, valid},  32'h1);
        check("ld1.im_se",  im_se,           32'h00001FF8);

        // Negative immediate.
        ins  = 32'hA822FFFF;
        pcp4 = 32'd8;
        tick();
        check("ld2.im",    {16'h0, im},    32'h0000FFFF);
        check("ld2.im_se", im_se,          32'hFFFFFFFF);
        check("ld2.rt_ft", {27'h0, rt_ft}, 32'h02);
        check("ld2.pcp4o", pcp4o,          32'd8);

        // Jump-target view.
        ins  = 32'hAAAAAAAA;
        pcp4 = 32'h0000000C;
        tick();
        check("ld3.ad",     {6'h0, ad},      32'h02AAAAAA);
        check("ld3.op",     {26'h0, op},     32'h2A);
        check("ld3.rs_fmt", {27'h0, rs_fmt}, 32'h15);
        check("ld3.im_se",  im_se,           32'hFFFFAAAA);

        // Changing the inputs between edges does not reach the outputs.
        ins  = 32'h12345678;
        pcp4 = 32'h55;
        #3;
        check("lat.ad",    {6'h0, ad}, 32'h02AAAAAA);
        check("lat.pcp4o", pcp4o,      32'h0000000C);

        // Load A8221FF8, then stall for two edges with new inputs applied.
        ins  = 32'hA8221FF8;
        pcp4 = 32'h10;
        tick();
        en   = 1'b0;
        ins  = 32'hAAAAAAAA;
        pcp4 = 32'h99;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("stall.fun",   {26'h0, fun},   32'h38);
            check("stall.im",    {16'h0, im},    32'h1FF8);
            check("stall.pcp4o", pcp4o,          32'h10);
            check("stall.valid", {31'h0, valid}, 32'h1);
        end

        // Flush with en=0 inserts a bubble.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_all_zero("flush");
        check("flush.fun", {26'h0, fun}, 32'h0);

`ifdef IFID_DECODE_FLAGS_EN
        // Format flags for R, J, JAL and COP1 opcodes.
        en   = 1'b1;
        ins  = 32'h00221820;   // SPECIAL (add)
        tick();
        check("flg_r.is_r",  {31'h0, is_r},  32'h1);
        check("flg_r.is_j",  {31'h0, is_j},  32'h0);
        check("flg_r.is_fp", {31'h0, is_fp}, 32'h0);
        ins  = 32'h08000010;   // J
        tick();
        check("flg_j.is_j",  {31'h0, is_j},  32'h1);
        check("flg_j.is_r",  {31'h0, is_r},  32'h0);
        ins  = 32'h0C000010;   // JAL
        tick();
        check("flg_jal.is_j", {31'h0, is_j}, 32'h1);
        ins  = 32'h46000000;   // COP1
        tick();
        check("flg_fp.is_fp", {31'h0, is_fp}, 32'h1);
        check("flg_fp.is_j",  {31'h0, is_j},  32'h0);
`endif

        // flush and en together: the bubble wins.
        en   = 1'b1;
        ins  = 32'h00000020;
        pcp4 = 32'h20;
        tick();
        check("pre_pri.valid", {31'h0, valid}, 32'h1);
        ins   = 32'hA8221FF8;
        pcp4  = 32'h24;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_all_zero("pri");
`ifdef IFID_DECODE_FLAGS_EN
        check("pri.is_r",  {31'h0, is_r},  32'h0);
        check("pri.is_j",  {31'h0, is_j},  32'h0);
        check("pri.is_fp", {31'h0, is_fp}, 32'h0);
`endif

        // Reset asserted mid-cycle clears the contents immediately.
        ins  = 32'hAAAAAAAA;
        pcp4 = 32'h30;
        tick();
        check("pre_rst.pcp4o", pcp4o, 32'h30);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        #1;
        rst_n = 1'b1;
        ins   = 32'hA822FFFF;
        pcp4  = 32'h34;
        #1;
        check("rel.valid", {31'h0, valid}, 32'h0);
        tick();
        check("rel.im_se", im_se,          32'hFFFFFFFF);
        check("rel.pcp4o", pcp4o,          32'h34);
        check("rel.valid", {31'h0, valid}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ifid_pipe_reg.md
Name: ifid_pipe_reg

Overview:
- Pipeline register between the Instruction Fetch and Instruction Decode stages of the modified MIPS core.
- Captures the fetched instruction word and PC+4 on each rising clock edge.
- Presents the instruction pre-split into all R/I/J/FR/FI field views for the decode stage.
- Supports stall (hold) and flush (bubble insertion) for hazard and branch handling.

Parameters:
- DATA_W, 32, width of the instruction word and PC+4; fixed at 32 for the MIPS field layout.

Ports:
- clk  input  1  pipeline clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- pcp4  input  32  PC+4 from the IF stage
- ins  input  32  fetched instruction from the IF stage
- en  input  1  load enable; 0 = stall (hold contents)
- flush  input  1  synchronous bubble insert
- pcp4o  output  32  registered PC+4
- op  output  6  instr[31:26]
- rs_fmt  output  5  instr[25:21] (rs, or fmt for FP)
- rt_ft  output  5  instr[20:16] (rt, or ft)
- rd_fs  output  5  instr[15:11] (rd, or fs)
- sh_fd  output  5  instr[10:6] (shamt, or fd)
- fun  output  6  instr[5:0]
- im  output  16  instr[15:0]
- im_se  output  32  im sign-extended to 32 bits
- ad  output  26  instr[25:0] jump target
- valid  output  1  1 = holds a real instruction, 0 = bubble

Behaviour:
- Internal state:
  - 32-bit instruction register IR.
  - 32-bit PC register PR.
  - 1-bit valid register V.
- Reset:
  - rst_n low forces IR=0, PR=0, V=0 immediately, without waiting for a clock edge.
  - All field outputs therefore read 0.
  - Release of rst_n takes effect at the next rising edge.
- At each rising clk with rst_n high, priority is: flush > stall > load.
  - flush=1: IR=0 (NOP), PR=0, V=0, regardless of en.
  - flush=0, en=0: IR, PR and V all hold.
  - flush=0, en=1: IR<=ins, PR<=pcp4, V<=1.
- Latency:
  - Exactly one cycle from ins/pcp4 to outputs.
  - A value applied before edge N is visible after edge N.
  - Inputs changed after edge N do not affect outputs until edge N+1.
- Field outputs are purely combinational slices of IR; no decoding by opcode. All views are driven simultaneously for every instruction format.
- im_se = {16{IR[15]}, IR[15:0]}.
- ad = IR[25:0]; no PC concatenation inside this block.
- pcp4o = PR, passed through unmodified with no arithmetic.
- No X propagation: every output is defined from reset onward.

Optional Feature:
- Macro: IFID_DECODE_FLAGS_EN.
- When defined, three extra 1-bit outputs are added, computed combinationally from IR:
  - is_r = (op==6'b000000)
  - is_j = (op==6'b000010 or op==6'b000011)
  - is_fp = (op==6'b010001)
  - All three read 0 whenever valid=0.
- When undefined, these ports do not exist and the behaviour above is unchanged.

Test Plan:
- Reset with rst_n=0 mid-cycle -> all outputs 0 and valid=0 immediately, before any clock edge.
- Load ins=32'hA8221FF8, pcp4=4, en=1 -> after the edge: op=101010, rs_fmt=00001, rt_ft=00010, rd_fs=00011, sh_fd=11111, fun=111000, pcp4o=4, valid=1.
- Load ins=32'hA822FFFF -> next edge: im=16'hFFFF, im_se=32'hFFFFFFFF, rt_ft=00010.
- Load ins=32'hAAAAAAAA -> next edge: ad=26'h2AAAAAA, op=101010.
- Stall then flush:
  - With IR=32'hA8221FF8, apply en=0 and ins=32'hAAAAAAAA for 2 edges -> outputs unchanged.
  - Then apply flush=1 with en=0 -> IR=0, pcp4o=0, valid=0.
- Flush/en priority: flush=1 and en=1 together -> bubble wins. With IFID_DECODE_FLAGS_EN defined, is_r/is_j/is_fp are all 0.
